// File: rtl/ppu_dma_writer_if.sv
// Bus bundle between the DMA writer, its staging RAM read port and the PPU CPU-side write port.
// The master modport is the DMA side; the slave modport is the RAM + PPU side.
interface ppu_dma_writer_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32,
  parameter int SRC_AW = 10
);
  logic              src_rd;
  logic [SRC_AW-1:0] src_addr;
  logic [DATA_W-1:0] src_data;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] write_data;
  logic              write;
  logic              chipselect;
  logic              bus_ready;

  modport master (
    output src_rd, src_addr, address, write_data, write, chipselect,
    input  src_data, bus_ready
  );

  modport slave (
    input  src_rd, src_addr, address, write_data, write, chipselect,
    output src_data, bus_ready
  );
endinterface

// File: rtl/ppu_dma_writer.sv
// Copies a block of words from the staging RAM into PPU memory, one read/fetch/write triple per word,
// optionally holding off each read until vblank so OAM and tile updates never tear.
module ppu_dma_writer #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32,
  parameter int SRC_AW = 10,
  parameter int LEN_W  = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [SRC_AW-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  input  logic [LEN_W-1:0]  length,
  input  logic              vblank_sync,
  input  logic              vblank,
  output logic              busy,
  output logic              done,
  ppu_dma_writer_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_VB,
    S_READ,
    S_FETCH,
    S_WRITE,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [SRC_AW-1:0] r_src_ptr;
  logic [ADDR_W-1:0] r_dst_ptr;
  logic [LEN_W-1:0]  r_remain;
  logic              r_sync;
  logic [DATA_W-1:0] r_wdata;
  logic              w_launch;
  logic              w_accept;

  assign w_launch = (r_state == S_IDLE) && start && !abort;
  assign w_accept = (r_state == S_WRITE) && bus.bus_ready;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // The vblank gate is evaluated on every transition into READ, so a read is never issued outside vblank.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_launch) begin
          if (length == '0) begin
            w_next = S_DONE;
          end else if (vblank_sync && !vblank) begin
            w_next = S_WAIT_VB;
          end else begin
            w_next = S_READ;
          end
        end
      end
      S_WAIT_VB: begin
        if (vblank) begin
          w_next = S_READ;
        end
      end
      S_READ:  w_next = S_FETCH;
      S_FETCH: w_next = S_WRITE;
      S_WRITE: begin
        if (bus.bus_ready) begin
          if (r_remain == LEN_W'(1)) begin
            w_next = S_DONE;
          end else if (r_sync && !vblank) begin
            w_next = S_WAIT_VB;
          end else begin
            w_next = S_READ;
          end
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (abort) begin
      w_next = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_src_ptr <= '0;
      r_dst_ptr <= '0;
      r_remain  <= '0;
      r_sync    <= 1'b0;
      r_wdata   <= '0;
    end else begin
      if (w_launch) begin
        r_src_ptr <= src_base;
        r_dst_ptr <= dst_base;
        r_remain  <= length;
        r_sync    <= vblank_sync;
      end
      if (r_state == S_FETCH) begin
        r_wdata <= bus.src_data;
      end
      // Pointers wrap naturally at their own widths.
      if (w_accept) begin
        r_src_ptr <= r_src_ptr + 1'b1;
        r_dst_ptr <= r_dst_ptr + 1'b1;
        r_remain  <= r_remain - 1'b1;
      end
    end
  end

  assign busy           = (r_state != S_IDLE);
  assign done           = (r_state == S_DONE);
  assign bus.src_rd     = (r_state == S_READ);
  assign bus.src_addr   = r_src_ptr;
  assign bus.address    = r_dst_ptr;
  assign bus.write_data = r_wdata;
  assign bus.write      = (r_state == S_WRITE);
  assign bus.chipselect = (r_state == S_WRITE);

endmodule

// File: tb/tb_ppu_dma_writer.sv
// Directed bench for ppu_dma_writer: staging RAM model, write logger and cycle-exact checks.
// Inputs change 1 ns after the rising edge; outputs are sampled there or on the falling edge.
module tb_ppu_dma_writer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        abort;
  logic [9:0]  src_base;
  logic [11:0] dst_base;
  logic [9:0]  length;
  logic        vblank_sync;
  logic        vblank;
  logic        busy;
  logic        done;

  ppu_dma_writer_if #(.ADDR_W(12), .DATA_W(32), .SRC_AW(10)) bus_if ();

  ppu_dma_writer #(.ADDR_W(12), .DATA_W(32), .SRC_AW(10), .LEN_W(10)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .abort       (abort),
    .src_base    (src_base),
    .dst_base    (dst_base),
    .length      (length),
    .vblank_sync (vblank_sync),
    .vblank      (vblank),
    .busy        (busy),
    .done        (done),
    .bus         (bus_if.master)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:1023];
  logic [11:0] log_addr [$];
  logic [31:0] log_data [$];
  int          rd_cnt;
  int          done_cnt;
  int          n_checks;
  int          n_pass;
  int          n_fail;

  always @(posedge clk) begin
    if (bus_if.src_rd) bus_if.src_data <= mem[bus_if.src_addr];
  end

  always @(negedge clk) begin
    if (reset === 1'b1 && bus_if.write && bus_if.bus_ready) begin
      log_addr.push_back(bus_if.address);
      log_data.push_back(bus_if.write_data);
      $display("write addr=0x%03h data=0x%08h", bus_if.address, bus_if.write_data);
    end
    if (bus_if.src_rd) rd_cnt++;
    if (done) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [9:0] s, input logic [11:0] d, input logic [9:0] n,
                        input logic sync);
    src_base    = s;
    dst_base    = d;
    length      = n;
    vblank_sync = sync;
    start       = 1'b1;
    tick();
    start       = 1'b0;
  endtask

  task automatic clear_logs;
    log_addr.delete();
    log_data.delete();
    rd_cnt   = 0;
    done_cnt = 0;
  endtask

  task automatic wait_idle(input string tag, input int max);
    int i;
    i = 0;
    while (busy && i < max) begin
      tick();
      i++;
    end
    check(tag, busy, 1'b0);
  endtask

  task automatic check_log(input string tag, input int n, input logic [11:0] a0,
                           input logic [31:0] d0);
    check({tag, "_count"}, log_addr.size(), n);
    for (int i = 0; i < n && i < log_addr.size(); i++) begin
      check({tag, "_addr"}, log_addr[i], 12'(a0 + 12'(i)));
      check({tag, "_data"}, log_data[i], d0 + 32'(i));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int held;
    int rd0;
    int n100;
    logic wexp;

    n_checks = 0;
    n_pass   = 0;
    n_fail   = 0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h5500_0000 + 32'(i);
    for (int i = 0; i < 4; i++) mem[16 + i] = 32'hA0 + 32'(i);
    mem[10'h3FE] = 32'h11;
    mem[10'h3FF] = 32'h22;
    mem[10'h000] = 32'h33;

    reset       = 1'b0;
    start       = 1'b1;
    abort       = 1'b0;
    src_base    = 10'h010;
    dst_base    = 12'h100;
    length      = 10'd4;
    vblank_sync = 1'b0;
    vblank      = 1'b0;
    bus_if.bus_ready = 1'b1;
    clear_logs();

    // Reset held with start asserted
    for (int c = 0; c < 3; c++) begin
      tick();
      check("rst_ctrl", {busy, done, bus_if.src_rd, bus_if.write, bus_if.chipselect}, 5'b0);
      check("rst_addr", bus_if.address, 12'h0);
      check("rst_src", bus_if.src_addr, 10'h0);
      check("rst_data", bus_if.write_data, 32'h0);
    end
    reset = 1'b1;
    start = 1'b0;
    tick();
    check("rst_idle", busy, 1'b0);

    // Basic 4-word copy, cycle exact
    clear_logs();
    launch(10'h010, 12'h100, 10'd4, 1'b0);
    for (int c = 1; c <= 14; c++) begin
      wexp = (c % 3 == 0) && (c <= 12);
      check("t2_write", {bus_if.write, bus_if.chipselect}, {wexp, wexp});
      if (wexp) begin
        check("t2_addr", bus_if.address, 12'h100 + 12'(c / 3 - 1));
        check("t2_data", bus_if.write_data, 32'hA0 + 32'(c / 3 - 1));
      end
      check("t2_done", done, (c == 13));
      check("t2_busy", busy, (c <= 13));
      tick();
    end
    check_log("t2_log", 4, 12'h100, 32'hA0);

    // Stall the first write for 5 cycles
    clear_logs();
    bus_if.bus_ready = 1'b0;
    launch(10'h010, 12'h100, 10'd4, 1'b0);
    held = 0;
    for (int i = 0; i < 40 && log_addr.size() == 0; i++) begin
      if (bus_if.write) begin
        held++;
        check("t3_hold_addr", bus_if.address, 12'h100);
        check("t3_hold_data", bus_if.write_data, 32'hA0);
        if (held == 6) bus_if.bus_ready = 1'b1;
      end
      tick();
    end
    check("t3_held_cycles", held, 6);
    wait_idle("t3_idle", 40);
    n100 = 0;
    foreach (log_addr[i]) if (log_addr[i] == 12'h100) n100++;
    check("t3_once", n100, 1);
    check_log("t3_log", 4, 12'h100, 32'hA0);

    // vblank-gated transfer with a pause mid-block
    clear_logs();
    vblank = 1'b0;
    launch(10'h010, 12'h100, 10'd4, 1'b1);
    repeat (20) tick();
    check("t4_wait_busy", busy, 1'b1);
    check("t4_no_rd", rd_cnt, 0);
    check("t4_no_wr", log_addr.size(), 0);
    vblank = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (bus_if.write && bus_if.address == 12'h101) begin
        vblank = 1'b0;
        break;
      end
      tick();
    end
    check("t4_second_wr", {bus_if.write, vblank}, 2'b10);
    tick();
    rd0 = rd_cnt;
    repeat (10) tick();
    check("t4_pause_rd", rd_cnt, rd0);
    check("t4_pause_wr", log_addr.size(), 2);
    check("t4_pause_busy", busy, 1'b1);
    vblank = 1'b1;
    wait_idle("t4_idle", 60);
    check_log("t4_log", 4, 12'h100, 32'hA0);
    vblank = 1'b0;

    // Address wrap on both pointers
    clear_logs();
    launch(10'h3FE, 12'hFFE, 10'd3, 1'b0);
    wait_idle("t5_idle", 30);
    check("t5_count", log_addr.size(), 3);
    if (log_addr.size() == 3) begin
      check("t5_a0", log_addr[0], 12'hFFE);
      check("t5_a1", log_addr[1], 12'hFFF);
      check("t5_a2", log_addr[2], 12'h000);
      check("t5_d0", log_data[0], 32'h11);
      check("t5_d1", log_data[1], 32'h22);
      check("t5_d2", log_data[2], 32'h33);
    end

    // Empty transfer
    clear_logs();
    launch(10'h000, 12'h123, 10'd0, 1'b0);
    check("t5z_done", {done, busy, bus_if.write}, 3'b110);
    tick();
    check("t5z_after", {done, busy}, 2'b00);
    check("t5z_nowr", log_addr.size(), 0);
    check("t5z_nord", rd_cnt, 0);

    // Abort during a stalled write
    clear_logs();
    bus_if.bus_ready = 1'b0;
    launch(10'h010, 12'h100, 10'd4, 1'b0);
    for (int i = 0; i < 10 && !bus_if.write; i++) tick();
    check("t6_in_write", bus_if.write, 1'b1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t6_abort", {bus_if.write, bus_if.chipselect, busy, bus_if.src_rd}, 4'b0);
    bus_if.bus_ready = 1'b1;
    repeat (5) tick();
    check("t6_no_done", done_cnt, 0);
    check("t6_no_wr", log_addr.size(), 0);

    // start while busy is ignored
    clear_logs();
    launch(10'h010, 12'h100, 10'd4, 1'b0);
    repeat (4) tick();
    src_base = 10'h3FE;
    dst_base = 12'h200;
    length   = 10'd1;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    wait_idle("t6_idle", 40);
    check_log("t6_log", 4, 12'h100, 32'hA0);
    check("t6_done_once", done_cnt, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
